// File: rtl/alu_share_pkg.sv
// Shared types for the ALU sharing controller: op codes, FSM states, legal-op check.
// The legal-op check is only consulted when ALU_SHARE_OPCHECK_EN is defined.
package alu_share_pkg;

    localparam int unsigned OP_W = 3;

    typedef logic [OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 3'b000;
    localparam alu_op_t ALU_SUB = 3'b001;
    localparam alu_op_t ALU_AND = 3'b010;
    localparam alu_op_t ALU_XOR = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input alu_op_t op);
        logic ok;
        ok = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester-side request/response bundle for alu_share_ctrl.
interface alu_share_ctrl_if
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 2
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][WIDTH-1:0] req_a;
    logic [NREQ-1:0][WIDTH-1:0] req_b;
    alu_op_t [NREQ-1:0]         req_ctrl;
    logic [NREQ-1:0]            rsp_valid;
    logic [NREQ-1:0]            rsp_ready;
    logic [WIDTH-1:0]           rsp_result;
    logic                       rsp_eq;
    logic                       rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_eq, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_eq, rsp_err
    );
endinterface

// File: rtl/alu_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above i_ptr, wrapping.
module rr_pick #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);
    logic [IDX_W-1:0] w_k;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_k   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_k = IDX_W'((32'(i_ptr) + i) % NREQ);
            if (!o_any && i_req[w_k]) begin
                o_any      = 1'b1;
                o_gnt[w_k] = 1'b1;
                o_idx      = w_k;
            end
        end
    end
endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one external ALU among NREQ requesters (IDLE -> EXEC -> RESP).
// Define ALU_SHARE_OPCHECK_EN to reject illegal ops with rsp_err and bypass the ALU.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_ctrl_if.slave  bus,
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output alu_op_t          alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_eq
);
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_gnt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    alu_op_t          r_op_ctrl;
    logic [WIDTH-1:0] r_res;
    logic             r_eq;
    logic [NREQ-1:0]  r_rsp_valid;

    logic [NREQ-1:0]  w_pick_oh;
    logic [PTR_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_accept;
    logic             w_rsp_fire;
    logic             w_legal;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (PTR_W)
    ) u_rr_pick (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_oh),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Grant is offered only in IDLE and never while reset is held.
    assign w_accept      = rst_n && (r_state == S_IDLE) && w_pick_any;
    assign bus.req_ready = w_accept ? w_pick_oh : '0;
    assign w_rsp_fire    = (r_state == S_RESP) && bus.rsp_ready[r_gnt];

`ifdef ALU_SHARE_OPCHECK_EN
    logic r_err;
    assign w_legal     = op_legal(bus.req_ctrl[w_pick_idx]);
    assign bus.rsp_err = r_err;
`else
    assign w_legal     = 1'b1;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_legal ? S_EXEC : S_RESP;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_fire) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand, result and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_ctrl   <= ALU_ADD;
            r_res       <= '0;
            r_eq        <= 1'b0;
            r_rsp_valid <= '0;
`ifdef ALU_SHARE_OPCHECK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_gnt <= w_pick_idx;
                if (w_legal) begin
                    r_op_a    <= bus.req_a[w_pick_idx];
                    r_op_b    <= bus.req_b[w_pick_idx];
                    r_op_ctrl <= bus.req_ctrl[w_pick_idx];
                end
`ifdef ALU_SHARE_OPCHECK_EN
                else begin
                    r_res       <= '0;
                    r_eq        <= 1'b0;
                    r_err       <= 1'b1;
                    r_rsp_valid <= w_pick_oh;
                end
`endif
            end
            if (r_state == S_EXEC) begin
                r_res       <= alu_result;
                r_eq        <= alu_eq;
                r_rsp_valid <= NREQ'(1) << r_gnt;
`ifdef ALU_SHARE_OPCHECK_EN
                r_err       <= 1'b0;
`endif
            end
            if (w_rsp_fire) begin
                r_rsp_valid <= '0;
                r_ptr       <= (r_gnt == PTR_W'(NREQ - 1)) ? '0 : r_gnt + PTR_W'(1);
            end
        end
    end

    assign alu_srca       = r_op_a;
    assign alu_srcb       = r_op_b;
    assign alu_ctrl       = r_op_ctrl;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_res;
    assign bus.rsp_eq     = r_eq;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU; honours ALU_SHARE_OPCHECK_EN.
module tb_alu_share_ctrl;
    import alu_share_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREQ  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] alu_srca;
    logic [WIDTH-1:0] alu_srcb;
    alu_op_t          alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_eq;

    int n_pass  = 0;
    int n_total = 0;

    alu_share_ctrl_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus_if ();

    alu_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if.slave),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_eq     (alu_eq)
    );

    always #5 clk = ~clk;

    // External ALU stand-in; unlisted ops return a|b.
    always_comb begin
        case (alu_ctrl)
            ALU_ADD: alu_result = alu_srca + alu_srcb;
            ALU_SUB: alu_result = alu_srca - alu_srcb;
            ALU_AND: alu_result = alu_srca & alu_srcb;
            ALU_XOR: alu_result = alu_srca ^ alu_srcb;
            default: alu_result = alu_srca | alu_srcb;
        endcase
        alu_eq = (alu_srca == alu_srcb);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n            = 1'b0;
        bus_if.req_valid = 2'b11;
        bus_if.req_a[0]  = 32'd1;
        bus_if.req_b[0]  = 32'd1;
        bus_if.req_ctrl[0] = ALU_ADD;
        bus_if.req_a[1]  = 32'hF0;
        bus_if.req_b[1]  = 32'hFF;
        bus_if.req_ctrl[1] = ALU_XOR;
        bus_if.rsp_ready = 2'b11;
        tick();
        tick();

        check("rst_req_ready", 32'(bus_if.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'h0);
        check("rst_rsp_result", bus_if.rsp_result, 32'h0);
        check("rst_rsp_eq", 32'(bus_if.rsp_eq), 32'h0);
        check("rst_rsp_err", 32'(bus_if.rsp_err), 32'h0);
        check("rst_alu_srca", alu_srca, 32'h0);
        check("rst_alu_srcb", alu_srcb, 32'h0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);

        // Contention: both valid, grants alternate 0,1,0,1.
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("cont_ready", 32'(bus_if.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            tick();
            check("cont_rsp_valid", 32'(bus_if.rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
            check("cont_result", bus_if.rsp_result, (k % 2 == 0) ? 32'h2 : 32'h0F);
            tick();
        end
        bus_if.req_valid = 2'b00;
        tick();

        // Single op: 5+3 from requester 0.
        bus_if.req_a[0]    = 32'd5;
        bus_if.req_b[0]    = 32'd3;
        bus_if.req_ctrl[0] = ALU_ADD;
        bus_if.req_valid   = 2'b01;
        #1;
        check("single_ready_T", 32'(bus_if.req_ready), 32'h1);
        tick();
        bus_if.req_valid = 2'b00;
        check("single_rsp_T1", 32'(bus_if.rsp_valid), 32'h0);
        check("single_srca", alu_srca, 32'd5);
        tick();
        check("single_rsp_T2", 32'(bus_if.rsp_valid), 32'h1);
        check("single_result", bus_if.rsp_result, 32'd8);
        check("single_eq", 32'(bus_if.rsp_eq), 32'h0);
        check("single_err", 32'(bus_if.rsp_err), 32'h0);
        tick();
        bus_if.req_valid = 2'b01;
        #1;
        check("single_ready_T3", 32'(bus_if.req_ready), 32'h1);
        bus_if.req_valid = 2'b00;
        tick();

        // Equality: requester 1 subtracts equal operands.
        bus_if.req_a[1]    = 32'hDEADBEEF;
        bus_if.req_b[1]    = 32'hDEADBEEF;
        bus_if.req_ctrl[1] = ALU_SUB;
        bus_if.req_valid   = 2'b10;
        #1;
        check("eq_ready", 32'(bus_if.req_ready), 32'h2);
        tick();
        bus_if.req_valid = 2'b00;
        tick();
        check("eq_rsp_valid", 32'(bus_if.rsp_valid), 32'h2);
        check("eq_result", bus_if.rsp_result, 32'h0);
        check("eq_flag", 32'(bus_if.rsp_eq), 32'h1);
        tick();

        // Backpressure: ptr=0, both valid, requester 0 wins; 7&9=1 held for 5 cycles.
        bus_if.req_a[0]    = 32'd7;
        bus_if.req_b[0]    = 32'd9;
        bus_if.req_ctrl[0] = ALU_AND;
        bus_if.req_a[1]    = 32'd1;
        bus_if.req_b[1]    = 32'd2;
        bus_if.req_ctrl[1] = ALU_ADD;
        bus_if.rsp_ready   = 2'b10;
        bus_if.req_valid   = 2'b11;
        #1;
        check("bp_ready", 32'(bus_if.req_ready), 32'h1);
        tick();
        bus_if.req_valid = 2'b10;
        check("bp_exec_ready", 32'(bus_if.req_ready), 32'h0);
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_valid", 32'(bus_if.rsp_valid), 32'h1);
            check("bp_hold_result", bus_if.rsp_result, 32'h1);
            check("bp_hold_ready", 32'(bus_if.req_ready), 32'h0);
            tick();
        end
        bus_if.rsp_ready = 2'b01;
        #1;
        check("bp_6th_valid", 32'(bus_if.rsp_valid), 32'h1);
        tick();
        check("bp_done_valid", 32'(bus_if.rsp_valid), 32'h0);
        check("bp_next_ready", 32'(bus_if.req_ready), 32'h2);
        bus_if.rsp_ready = 2'b11;

        // Reset mid-op: requester 1 accepted, reset asserted during EXEC.
        tick();
        bus_if.req_valid = 2'b10;
        check("rmid_srca", alu_srca, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rmid_srca_rst", alu_srca, 32'h0);
        check("rmid_ready_rst", 32'(bus_if.req_ready), 32'h0);
        check("rmid_valid_rst", 32'(bus_if.rsp_valid), 32'h0);
        tick();
        rst_n            = 1'b1;
        bus_if.req_valid = 2'b00;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rmid_no_rsp", 32'(bus_if.rsp_valid), 32'h0);
        end
        bus_if.req_valid = 2'b11;
        #1;
        check("rmid_ptr0", 32'(bus_if.req_ready), 32'h1);
        bus_if.req_valid = 2'b00;
        tick();

        // Illegal op 3'b111 from requester 0.
        bus_if.req_a[0]    = 32'hF0;
        bus_if.req_b[0]    = 32'h0F;
        bus_if.req_ctrl[0] = 3'b111;
        bus_if.req_valid   = 2'b01;
        #1;
        check("op_ready", 32'(bus_if.req_ready), 32'h1);
        tick();
        bus_if.req_valid = 2'b00;
`ifdef ALU_SHARE_OPCHECK_EN
        check("op_rsp_T1", 32'(bus_if.rsp_valid), 32'h1);
        check("op_err", 32'(bus_if.rsp_err), 32'h1);
        check("op_result", bus_if.rsp_result, 32'h0);
        check("op_eq", 32'(bus_if.rsp_eq), 32'h0);
        check("op_srca_kept", alu_srca, 32'h0);
        tick();
        check("op_done", 32'(bus_if.rsp_valid), 32'h0);
`else
        check("op_rsp_T1", 32'(bus_if.rsp_valid), 32'h0);
        check("op_srca", alu_srca, 32'hF0);
        tick();
        check("op_rsp_T2", 32'(bus_if.rsp_valid), 32'h1);
        check("op_err", 32'(bus_if.rsp_err), 32'h0);
        check("op_result", bus_if.rsp_result, 32'hFF);
        tick();
        check("op_done", 32'(bus_if.rsp_valid), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing controller that shares one combinational ALU (32-bit; ops add/sub/and/xor; result plus equality flag) between NREQ requesters, e.g. the main datapath and a branch/address unit.
- Arbitrates round-robin and registers the operands into the ALU.
- Captures the result and returns it to the granted requester over a valid/ready handshake.
- Instantiated beside the ALU; the ALU itself is external and driven through the alu_* ports.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- NREQ, 2, number of requesters (≥2)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  NREQ×WIDTH  operand A per requester
- req_b  in  NREQ×WIDTH  operand B per requester
- req_ctrl  in  NREQ×3  ALU op per requester
- rsp_valid  out  NREQ  per-requester response valid (one-hot or zero)
- rsp_ready  in  NREQ  per-requester response accept
- rsp_result  out  WIDTH  shared response data
- rsp_eq  out  1  shared equality flag
- rsp_err  out  1  illegal-op flag (see Configuration)
- alu_srca, alu_srcb  out  WIDTH  to ALU
- alu_ctrl  out  3  to ALU
- alu_result  in  WIDTH  from ALU
- alu_eq  in  1  from ALU

## Operation
The FSM is IDLE → EXEC → RESP → IDLE.

**IDLE**
- If any req_valid is high, the round-robin pick g (starting at ptr, ascending mod NREQ) gets req_ready[g]=1 combinationally in the same cycle.
- req_ready depends combinationally on req_valid; requesters must not derive req_valid from req_ready.
- On transfer (req_valid[g] and req_ready[g] both high): latch req_a[g], req_b[g] and req_ctrl[g] into op_a, op_b and op_ctrl; latch g into gnt; go to EXEC.

**EXEC**
- alu_srca, alu_srcb and alu_ctrl are driven from op_a, op_b and op_ctrl; these are registers and are held in all states.
- At the clock edge, alu_result and alu_eq are captured into res_q and eq_q; go to RESP.

**RESP**
- rsp_valid[gnt]=1; rsp_result=res_q; rsp_eq=eq_q.
- Hold until rsp_ready[gnt] is high. Then go to IDLE and set ptr=(gnt+1) mod NREQ.
- rsp_ready on non-granted indices is ignored.

**Datapath rules**
- Results are exact ALU output, not re-extended.
- req_valid of non-granted requesters may stay high indefinitely; they are not dropped.
- Only one operation is in flight; there is no queueing.
- req_valid dropping in EXEC/RESP has no effect.
- Reset at any point aborts the in-flight operation with no response.

## Timing
- Reset values:
  - state=IDLE, ptr=0, gnt=0
  - req_ready=0 (while rst_n low), rsp_valid=0
  - rsp_result=0, rsp_eq=0, rsp_err=0
  - alu_srca=0, alu_srcb=0, alu_ctrl=3'b000
- Accept in cycle T; ALU evaluates in T+1; rsp_valid goes high in T+2.
- If rsp_ready is already high at T+2, the next accept can occur at T+3. Peak throughput is one op per 3 cycles.
- Backpressure: rsp_valid and rsp_result stay stable until accepted.
- No request is accepted while in EXEC or RESP.
- Simultaneous requests: the lowest index at or above ptr wins. With NREQ=2 and both requesters continuously valid, grants alternate.

## Configuration
Macro: ALU_SHARE_OPCHECK_EN.
- **Defined:** legal req_ctrl values are 3'b000, 3'b001, 3'b010 and 3'b100.
  - An accepted illegal op skips EXEC: IDLE → RESP directly.
  - The response has rsp_result=0, rsp_eq=0, rsp_err=1, with rsp_valid at T+1.
  - alu_* outputs are not updated for an illegal op.
  - For legal ops, rsp_err=0.
- **Undefined:** every op goes through EXEC, the ALU's default output is returned unchanged, and rsp_err is tied 0.

## Structure
- Package alu_share_pkg holds:
  - the 3-bit ALU op type and constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_XOR=3'b100
  - the FSM state enum (S_IDLE, S_EXEC, S_RESP)
  - the legal-op check function
- Sub-module rr_pick: a combinational round-robin picker with inputs req[NREQ] and ptr, producing a one-hot grant and its index. It is reusable by other arbiters.

## Test plan
- **Single op:** requester 0 sends a=5, b=3, ctrl=000 at T; rsp_ready=1 → rsp_valid[0] at T+2, rsp_result=8, rsp_eq=0; req_ready[0] high again at T+3.
- **Equality:** requester 1 sends a=b=0xDEADBEEF, ctrl=001 → rsp_result=0, rsp_eq=1, rsp_valid=2'b10.
- **Contention:** both requesters continuously valid from reset (req 0 add 1+1, req 1 xor 0xF0^0xFF) → grant order 0,1,0,1; results 2 and 0x0F alternate.
- **Backpressure:** hold rsp_ready=0 for 5 cycles in RESP → rsp_result held stable; req_ready=0 throughout; accept completes on the 6th cycle.
- **Reset mid-op:** assert rst_n=0 during EXEC → all outputs at reset values immediately; no response after release; ptr=0.
- **Opcheck (macro on):** ctrl=3'b111 → rsp_valid at T+1, rsp_err=1, rsp_result=0. With the macro off: response at T+2, rsp_err=0, result equal to the ALU default.
